// File: rtl/deser_lane.sv
// One lane of the demultiplexing deserializer: MSB-first shift register,
// bit counter, output word register and valid flag.
module deser_lane #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             datain,
    input  logic             ack,
    output logic [WIDTH-1:0] word,
    output logic             valid
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Only WIDTH-1 bits are stored; the incoming bit completes the word.
    logic [WIDTH-2:0] sh;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] nxt;

    assign nxt = {sh, datain};

    always_ff @(posedge clk) begin
        if (rst) begin
            sh    <= '0;
            cnt   <= '0;
            word  <= '0;
            valid <= 1'b0;
        end else begin
            if (bit_en) begin
                sh <= nxt[WIDTH-2:0];
                if (cnt == LAST) begin
                    word  <= nxt;
                    valid <= 1'b1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (ack && valid) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux_deser4.sv
// 1-to-4 demultiplexing deserializer: {sel1, sel0} steers the serial stream
// into one of four independent lanes, each with its own valid/ack handshake.
module demux_deser4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             datain,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic             sel0,
    input  logic             sel1,
    output logic [WIDTH-1:0] dataout0,
    output logic [WIDTH-1:0] dataout1,
    output logic [WIDTH-1:0] dataout2,
    output logic [WIDTH-1:0] dataout3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ack
);

    localparam int unsigned NLANES = 4;
    localparam int unsigned LW     = 2;

    logic [LW-1:0]     lane;
    logic              accept;
    logic [NLANES-1:0] bit_en;
    logic [WIDTH-1:0]  words [NLANES];

    assign lane     = {sel1, sel0};
    assign in_ready = ~out_valid[lane];
    assign accept   = valid_in & in_ready;

    always_comb begin
        bit_en = '0;
        bit_en[lane] = accept;
    end

    for (genvar k = 0; k < NLANES; k++) begin : g_lane
        deser_lane #(.WIDTH(WIDTH)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .bit_en (bit_en[k]),
            .datain (datain),
            .ack    (out_ack[k]),
            .word   (words[k]),
            .valid  (out_valid[k])
        );
    end

    assign dataout0 = words[0];
    assign dataout1 = words[1];
    assign dataout2 = words[2];
    assign dataout3 = words[3];

endmodule

// File: tb/tb_demux_deser4.sv
// Directed vector table plus hand-written ack/bubble sequence for demux_deser4.
module tb_demux_deser4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       datain = 1'b0;
    logic       valid_in = 1'b0;
    logic       in_ready;
    logic       sel0 = 1'b0;
    logic       sel1 = 1'b0;
    logic [7:0] dataout0, dataout1, dataout2, dataout3;
    logic [3:0] out_valid;
    logic [3:0] out_ack = 4'b0;

    int total = 0;
    int bad   = 0;

    demux_deser4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .datain    (datain),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .sel0      (sel0),
        .sel1      (sel1),
        .dataout0  (dataout0),
        .dataout1  (dataout1),
        .dataout2  (dataout2),
        .dataout3  (dataout3),
        .out_valid (out_valid),
        .out_ack   (out_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vin;
        logic       din;
        logic [1:0] sel;
        logic [3:0] ack;
        logic [3:0] ev;
        logic       er;
        logic [7:0] e0, e1, e2, e3;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic d,
                                input logic [1:0] s, input logic [3:0] a,
                                input logic [3:0] ev, input logic er,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        vec_t x;
        x.rst = r; x.vin = v; x.din = d; x.sel = s; x.ack = a;
        x.ev = ev; x.er = er; x.e0 = e0; x.e1 = e1; x.e2 = e2; x.e3 = e3;
        vecs.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic d,
                         input logic [1:0] s, input logic [3:0] a);
        rst = r; valid_in = v; datain = d; {sel1, sel0} = s; out_ack = a;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] c3;
        int waited;

        // 1. reset, then lane 0 <- 0xA5
        add(1, 1, 1, 2'd1, 4'hF, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 0, 0, 2'd0, 4'h0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        w = 8'hA5;
        for (int i = 0; i < 8; i++)
            add(0, 1, w[7-i], 2'd0, 4'h0, (i == 7) ? 4'b0001 : 4'b0000,
                (i == 7) ? 1'b0 : 1'b1, (i == 7) ? 8'hA5 : 8'h00, 8'h00, 8'h00, 8'h00);
        // 2. backpressure, then ack
        for (int i = 0; i < 5; i++)
            add(0, 1, i[0], 2'd0, 4'h0, 4'b0001, 0, 8'hA5, 8'h00, 8'h00, 8'h00);
        add(0, 0, 0, 2'd0, 4'b0001, 4'b0000, 1, 8'hA5, 8'h00, 8'h00, 8'h00);
        // 3. interleave: 0x3C upper nibble on lane 2, 0xFF on lane 1, lower nibble on lane 2
        w = 8'h3C;
        for (int i = 0; i < 4; i++)
            add(0, 1, w[7-i], 2'd2, 4'h0, 4'b0000, 1, 8'hA5, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++)
            add(0, 1, 1'b1, 2'd1, 4'h0, (i == 7) ? 4'b0010 : 4'b0000,
                (i == 7) ? 1'b0 : 1'b1, 8'hA5, (i == 7) ? 8'hFF : 8'h00, 8'h00, 8'h00);
        for (int i = 4; i < 8; i++)
            add(0, 1, w[7-i], 2'd2, 4'h0, (i == 7) ? 4'b0110 : 4'b0010,
                (i == 7) ? 1'b0 : 1'b1, 8'hA5, 8'hFF, (i == 7) ? 8'h3C : 8'h00, 8'h00);
        // 4. lane 3 completes 0x81 on the same edge lane 1 is acked
        w = 8'h81;
        for (int i = 0; i < 8; i++)
            add(0, 1, w[7-i], 2'd3, (i == 7) ? 4'b0010 : 4'b0000,
                (i == 7) ? 4'b1100 : 4'b0110, (i == 7) ? 1'b0 : 1'b1,
                8'hA5, 8'hFF, 8'h3C, (i == 7) ? 8'h81 : 8'h00);
        // 5. partial word on lane 0 and pending lanes 2/3, then reset, then 0x5A
        for (int i = 0; i < 5; i++)
            add(0, 1, 1'b1, 2'd0, 4'h0, 4'b1100, 1, 8'hA5, 8'hFF, 8'h3C, 8'h81);
        add(1, 1, 1, 2'd0, 4'h0, 4'b0000, 1, 8'h00, 8'h00, 8'h00, 8'h00);
        w = 8'h5A;
        for (int i = 0; i < 8; i++)
            add(0, 1, w[7-i], 2'd0, 4'h0, (i == 7) ? 4'b0001 : 4'b0000,
                (i == 7) ? 1'b0 : 1'b1, (i == 7) ? 8'h5A : 8'h00, 8'h00, 8'h00, 8'h00);
        // 6. idle with toggling sel/datain and stray acks on empty lanes
        for (int i = 0; i < 20; i++)
            add(0, 0, i[0], i[1:0], 4'b1110, 4'b0001, (i[1:0] == 2'd0) ? 1'b0 : 1'b1,
                8'h5A, 8'h00, 8'h00, 8'h00);

        #2;
        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].vin, vecs[n].din, vecs[n].sel, vecs[n].ack);
            tick();
            chk($sformatf("v%0d out_valid", n), 32'(out_valid), 32'(vecs[n].ev));
            chk($sformatf("v%0d in_ready", n), 32'(in_ready), 32'(vecs[n].er));
            chk($sformatf("v%0d dataout0", n), 32'(dataout0), 32'(vecs[n].e0));
            chk($sformatf("v%0d dataout1", n), 32'(dataout1), 32'(vecs[n].e1));
            chk($sformatf("v%0d dataout2", n), 32'(dataout2), 32'(vecs[n].e2));
            chk($sformatf("v%0d dataout3", n), 32'(dataout3), 32'(vecs[n].e3));
        end

        // Ack with a bit on the same lane: the bit is a dropped bubble.
        drive(0, 1, 1, 2'd0, 4'b0001);
        tick();
        chk("bubble out_valid", 32'(out_valid), 32'h0);
        chk("bubble in_ready", 32'(in_ready), 32'h1);
        // Back-to-back 0xC3 straight after the ack; a captured bubble bit would shift it.
        c3 = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, c3[7-i], 2'd0, 4'h0);
            tick();
        end
        drive(0, 0, 0, 2'd0, 4'h0);
        waited = 0;
        while (out_valid[0] !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk("b2b wait", 32'(waited), 32'h0);
        chk("b2b dataout0", 32'(dataout0), 32'hC3);
        chk("b2b out_valid", 32'(out_valid), 32'h1);
        // Stray ack on an empty lane leaves lane 0 pending.
        drive(0, 0, 0, 2'd2, 4'b0100);
        tick();
        chk("stray ack out_valid", 32'(out_valid), 32'h1);
        chk("stray ack dataout0", 32'(dataout0), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
